// File: rtl/fm_discriminator_gen.sv
// Iterative CORDIC phase/frequency discriminator: one vectoring iteration per
// clock, mode-folded phase error, frequency differencing and block averaging.
module fm_discriminator_gen #(
  parameter int IN_W     = 18,
  parameter int PH_W     = 12,
  parameter int MAG_W    = 13,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sync,
  input  logic [IN_W-1:0]  iIn,
  input  logic [IN_W-1:0]  qIn,
  input  logic [4:0]       demodMode,
  input  logic             clrOverrun,
  output logic [PH_W-1:0]  phase,
  output logic [PH_W-1:0]  phaseError,
  output logic [PH_W-1:0]  freq,
  output logic [PH_W-1:0]  freqError,
  output logic [MAG_W-1:0] mag,
  output logic [PH_W-1:0]  freqAvg,
  output logic             syncOut,
  output logic             avgValid,
  output logic             busy,
  output logic             overrun
);

  localparam logic [4:0] MODE_AM     = 5'd0;
  localparam logic [4:0] MODE_PM     = 5'd1;
  localparam logic [4:0] MODE_FM     = 5'd2;
  localparam logic [4:0] MODE_2FSK   = 5'd3;
  localparam logic [4:0] MODE_BPSK   = 5'd4;
  localparam logic [4:0] MODE_QPSK   = 5'd5;
  localparam logic [4:0] MODE_OQPSK  = 5'd6;
  localparam logic [4:0] MODE_UQPSK  = 5'd7;
  localparam logic [4:0] MODE_AUQPSK = 5'd8;
  localparam logic [4:0] MODE_AQPSK  = 5'd9;

  localparam int XW = IN_W + 2;
  localparam int KW = $clog2(PH_W);
  localparam logic [PH_W-1:0] HALF_TURN   = {1'b1, {(PH_W-1){1'b0}}};
  localparam logic [PH_W-1:0] EIGHTH_TURN = HALF_TURN >> 2;

  typedef enum logic [1:0] {IDLE, ROTATE, POST} stateT;

  stateT state, nextState;

  logic signed [XW-1:0] xReg, yReg, xShift, yShift, iExt, qExt;
  logic [PH_W-1:0]      zReg, atanK;
  logic [KW-1:0]        iter;
  logic [PH_W-1:0]      prevPhase, prevPhaseError;
  logic                 polarityFlag;
  logic [PH_W-1:0]      phaseErrNew, phaseDiff, freqNew;

  // Elaboration-time arctangent table, one entry per iteration, in turns.
  function automatic logic [PH_W-1:0] atanEntry(input int k);
    real turns;
    turns = $atan(1.0 / (2.0 ** k)) / (2.0 * 3.14159265358979);
    return PH_W'($rtoi(turns * (2.0 ** PH_W) + 0.5));
  endfunction

  logic [PH_W-1:0] atanTable [2**KW];
  for (genvar g = 0; g < 2**KW; g++) begin : gAtan
    assign atanTable[g] = atanEntry(g);
  end

  assign atanK  = atanTable[iter];
  assign xShift = xReg >>> iter;
  assign yShift = yReg >>> iter;
  assign iExt   = {{2{iIn[IN_W-1]}}, iIn};
  assign qExt   = {{2{qIn[IN_W-1]}}, qIn};
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    nextState = state;
    case (state)
      IDLE:    if (sync) nextState = ROTATE;
      ROTATE:  if (iter == KW'(PH_W-1)) nextState = POST;
      POST:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Pre-rotation folds the left half-plane into the right so vectoring converges.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      xReg <= '0;
      yReg <= '0;
      zReg <= '0;
      iter <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sync) begin
            iter <= '0;
            if (iIn[IN_W-1]) begin
              xReg <= -iExt;
              yReg <= -qExt;
              zReg <= HALF_TURN;
            end else begin
              xReg <= iExt;
              yReg <= qExt;
              zReg <= '0;
            end
          end
        end
        ROTATE: begin
          iter <= iter + 1'b1;
          if (!yReg[XW-1]) begin
            xReg <= xReg + yShift;
            yReg <= yReg - xShift;
            zReg <= zReg + atanK;
          end else begin
            xReg <= xReg - yShift;
            yReg <= yReg + xShift;
            zReg <= zReg - atanK;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    phaseErrNew = '0;
    case (demodMode)
      MODE_PM, MODE_FM, MODE_2FSK:        phaseErrNew = zReg;
      MODE_BPSK, MODE_UQPSK, MODE_AUQPSK: phaseErrNew = zReg << 1;
      MODE_QPSK, MODE_OQPSK, MODE_AQPSK:  phaseErrNew = (zReg - EIGHTH_TURN) << 2;
      MODE_AM:                            phaseErrNew = '0;
      default:                            phaseErrNew = '0;
    endcase
  end

  // An exact half-turn step has no sign; alternate the bias so it averages out.
  assign phaseDiff = zReg - prevPhase;
  assign freqNew   = (phaseDiff != HALF_TURN) ? phaseDiff :
                     (polarityFlag ? HALF_TURN + 1'b1 : HALF_TURN - 1'b1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase          <= '0;
      phaseError     <= '0;
      freq           <= '0;
      freqError      <= '0;
      mag            <= '0;
      syncOut        <= 1'b0;
      prevPhase      <= '0;
      prevPhaseError <= '0;
      polarityFlag   <= 1'b1;
      overrun        <= 1'b0;
    end else begin
      syncOut <= (state == POST);
      if (state == POST) begin
        phase          <= zReg;
        phaseError     <= phaseErrNew;
        freq           <= freqNew;
        freqError      <= phaseErrNew - prevPhaseError;
        mag            <= xReg[IN_W -: MAG_W];
        prevPhase      <= zReg;
        prevPhaseError <= phaseErrNew;
        if (phaseDiff == HALF_TURN) polarityFlag <= ~polarityFlag;
      end
      if (clrOverrun)      overrun <= 1'b0;
      if (sync && busy)    overrun <= 1'b1;
    end
  end

  if (AVG_LOG2 > 0) begin : gAvg
    localparam int AW = PH_W + AVG_LOG2;
    logic signed [AW-1:0] acc, accSum;
    logic [AVG_LOG2-1:0]  count;

    assign accSum = acc + {{AVG_LOG2{freqNew[PH_W-1]}}, freqNew};

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        acc      <= '0;
        count    <= '0;
        freqAvg  <= '0;
        avgValid <= 1'b0;
      end else begin
        avgValid <= 1'b0;
        if (state == POST) begin
          count <= count + 1'b1;
          if (&count) begin
            freqAvg  <= PH_W'(accSum >>> AVG_LOG2);
            avgValid <= 1'b1;
            acc      <= '0;
          end else begin
            acc <= accSum;
          end
        end
      end
    end
  end else begin : gNoAvg
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        freqAvg  <= '0;
        avgValid <= 1'b0;
      end else begin
        avgValid <= (state == POST);
        if (state == POST) freqAvg <= freqNew;
      end
    end
  end

endmodule

// File: doc/fm_discriminator_gen.md
# fm_discriminator_gen

Parametrised, iterative CORDIC phase/frequency discriminator for the demodulator datapath. It sits after the carrier/baseband mixer and feeds the carrier loop, the FM/PM output filters and the telemetry magnitude path. It improves on the fixed 12-bit discriminator in four ways:
- generic widths;
- a bit-serial (one iteration per clock) vectoring engine with busy/overrun handshake;
- a generic QPSK/BPSK error fold;
- an optional decimating frequency averager.

## Interface
Parameters:
- IN_W, 18, I/Q input width, signed two's complement.
- PH_W, 12, phase/freq width; full scale = one turn (2^PH_W counts).
- MAG_W, 13, magnitude output width, unsigned.
- AVG_LOG2, 2, frequency averaging depth exponent (0 = averager bypassed, freqAvg = freq).

Ports:
- clk  in  1  sample clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low.
- sync  in  1  input strobe; iIn/qIn valid this cycle.
- iIn  in  IN_W  in-phase sample.
- qIn  in  IN_W  quadrature sample.
- demodMode  in  5  MODE_* code from addressMap.v.
- clrOverrun  in  1  clears overrun.
- phase  out  PH_W  angle of (iIn,qIn).
- phaseError  out  PH_W  mode-folded phase error.
- freq  out  PH_W  per-sample phase difference.
- freqError  out  PH_W  phaseError difference.
- mag  out  MAG_W  uncompensated CORDIC magnitude.
- freqAvg  out  PH_W  block average of freq.
- syncOut  out  1  one-cycle strobe; phase/phaseError/freq/freqError/mag updated.
- avgValid  out  1  one-cycle strobe; freqAvg updated.
- busy  out  1  engine not in IDLE.
- overrun  out  1  sticky; a sync arrived while busy.

## Operation
- States: IDLE, ROTATE, POST.
- IDLE, sync=1: latch inputs, perform pre-rotation, go to ROTATE.
  - Pre-rotation: if iIn<0, x=-iIn, y=-qIn, z=2^(PH_W-1); else x=iIn, y=qIn, z=0.
  - x/y are held at IN_W+2 bits, sign-extended.
- ROTATE: iteration counter k runs 0..PH_W-1, one iteration per cycle.
  - Vectoring step: if y>=0, x+=y>>>k, y-=x>>>k, z+=atan_k; else the opposite signs.
  - atan_k = round(atan(2^-k)*2^PH_W/(2π)), held in a constant table.
  - After k=PH_W-1, go to POST.
- POST (one cycle), then IDLE:
  - phase = z (mod 2^PH_W).
  - mag = x[IN_W:IN_W+1-MAG_W], unsigned, not gain-compensated (gain ≈1.647).
  - phaseError, freq, freqError computed and registered (rules below); syncOut=1.
- phaseError by demodMode, sampled in POST:
  - AM or default: 0.
  - PM, FM, 2FSK: phase.
  - BPSK, UQPSK, AUQPSK: phase<<1.
  - QPSK, OQPSK, AQPSK: (phase−2^(PH_W-3))<<2.
  - All results mod 2^PH_W.
- freq: d = phase − prevPhase (mod 2^PH_W).
  - If d≠2^(PH_W-1): freq=d.
  - If d=2^(PH_W-1) (ambiguous half turn): freq=2^(PH_W-1)+1 when polarityFlag=1, else 2^(PH_W-1)−1; polarityFlag toggles.
  - prevPhase←phase.
- freqError = phaseError_new − prevPhaseError (mod 2^PH_W); prevPhaseError←phaseError_new.
- Averager (AVG_LOG2>0):
  - Signed accumulator, PH_W+AVG_LOG2 bits, adds freq on each syncOut.
  - After 2^AVG_LOG2 samples: freqAvg = acc>>>AVG_LOG2 (arithmetic shift, truncate), avgValid=1, accumulator reloads 0.
- Overrun: sync while busy drops that sample and sets overrun. Priority in the same cycle is clrOverrun, then set (set wins).

## Timing
- Latency: sync → syncOut is PH_W+2 cycles (1 latch, PH_W ROTATE, 1 POST; outputs registered at end of POST).
- Throughput: one sample per PH_W+2 cycles. sync is accepted again in the cycle after POST.
- busy is high from the cycle after an accepted sync through POST.
- avgValid coincides with the syncOut of the final sample in each block.
- Reset values:
  - All outputs, prevPhase, prevPhaseError, accumulator and sample count: 0.
  - polarityFlag: 1.
  - State: IDLE.
- Reset asserted mid-ROTATE aborts the sample; no syncOut is produced.
- The first sample after reset gives freq = phase, since prevPhase=0.
- Outputs hold between strobes.

## Test plan
- Reset mid-ROTATE (reset low at cycle 5 after sync) → busy=0, syncOut never pulses, all outputs 0; the next sync gives freq=phase.
- Defaults, iIn=65536, qIn=0, repeated → phase=0±2, mag=1686±2, freq=0 from the 2nd sample; syncOut exactly 14 cycles after each sync.
- Phasor advancing 1/16 turn per sample, FM mode → freq=256±2 steady, phaseError=phase, freqAvg=256±2 with avgValid every 4th syncOut.
- Alternating (65536,0)/(−65536,0) → freq sequence 0x801, 0x7FF, 0x801…
- QPSK mode, input at 45° → phaseError=0±4. BPSK mode, input at 180° → phaseError=0±2. AM mode → phaseError=0.
- sync reissued 3 cycles after an accepted sync → that sample ignored, overrun=1 until clrOverrun; clrOverrun coincident with another overrun leaves overrun=1.
